// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: credit-limited word fetches into a prefetch FIFO, with PCs,
// drained by decode over valid/ready; a branch redirect flushes the FIFO and discards in-flight data.
module riscv_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  logic        req_en_q;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  cnt_t        occ_q, occ_d;
  cnt_t        outst_q, outst_d;
  cnt_t        discard_q, discard_d;
  ptr_t        head_q, head_d, tail_q, tail_d;
  ptr_t        rp_rd_q, rp_rd_d, rp_wr_q, rp_wr_d;

  logic [31:0] instr_mem_q [DEPTH];
  logic [31:0] pc_mem_q    [DEPTH];
  logic [31:0] rpc_mem_q   [DEPTH];

  logic          grant, ret, push, pop;
  logic [CntW:0] credits_used;
  logic          unused_redirect_lsb;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign credits_used = {1'b0, occ_q} + {1'b0, outst_q};
  assign imem_req     = req_en_q && (credits_used < DepthC);
  assign imem_addr    = fetch_pc_q;

  assign grant = imem_req && imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign ret   = imem_rvalid && (outst_q != '0);
  assign pop   = if_valid && if_ready;
  assign push  = ret && !redirect && (discard_q == '0);

  assign if_valid = (occ_q != '0);
  assign if_instr = if_valid ? instr_mem_q[head_q] : NOP;
  assign if_pc    = if_valid ? pc_mem_q[head_q] : 32'h0;

  always_comb begin
    outst_d    = outst_q + cnt_t'(grant) - cnt_t'(ret);
    // The return-PC queue tracks every outstanding fetch, including ones to be discarded,
    // so it stays aligned with the memory's in-order responses across redirects.
    rp_wr_d    = grant ? ptr_inc(rp_wr_q) : rp_wr_q;
    rp_rd_d    = ret ? ptr_inc(rp_rd_q) : rp_rd_q;
    fetch_pc_d = fetch_pc_q;
    occ_d      = occ_q;
    discard_d  = discard_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (redirect) begin
      // A grant this cycle used the stale address, so it is only counted for discard.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      occ_d      = '0;
      head_d     = '0;
      tail_d     = '0;
      discard_d  = outst_d;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (ret && (discard_q != '0)) discard_d = discard_q - 1'b1;
      if (push) tail_d = ptr_inc(tail_q);
      if (pop) head_d = ptr_inc(head_q);
      occ_d = occ_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_en_q   <= 1'b0;
      fetch_pc_q <= RESET_PC;
      occ_q      <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      rp_rd_q    <= '0;
      rp_wr_q    <= '0;
    end else begin
      req_en_q   <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      rp_rd_q    <= rp_rd_d;
      rp_wr_q    <= rp_wr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (grant) rpc_mem_q[rp_wr_q] <= fetch_pc_q;
    if (push) begin
      instr_mem_q[tail_q] <= imem_rdata;
      pc_mem_q[tail_q]    <= rpc_mem_q[rp_rd_q];
    end
  end

endmodule
